half_layer_sequencer: RTL

Sequencer for one dense layer on the shared `half_fixed_vector_dot_vector` datapath. The block holds the datapath's `load_a`, `vector_a_in`, `in_valid` and `vector_b` inputs. For each neuron it loads the weight row, then streams the input vector, then collects `c` as that neuron's result. It sits between the weight/activation memories and the layer output buffer, and it owns the datapath exclusively.

---
 rtl/half_nn_pkg.sv | 12 +
 rtl/half_seq_addr_gen.sv | 27 ++
 rtl/half_layer_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/half_nn_pkg.sv
// half_nn_pkg: shared types and constants for the half-precision layer sequencer
package half_nn_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT, DONE} seq_state_t;
    localparam logic [15:0] HALF_ZERO     = 16'h0000;
    localparam logic [15:0] HALF_SIGN_BIT = 16'h8000;
    function automatic int chunks_of(input int length, input int mults);
        return length / mults;
    endfunction
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/half_seq_addr_gen.sv
// half_seq_addr_gen: wrapping chunk counter (up or down) with terminal-count flag
module half_seq_addr_gen
    import half_nn_pkg::*;
#(
    parameter int COUNT = 5,
    parameter bit DOWN  = 1'b0,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_en,
    output logic [AW-1:0] o_cnt,
    output logic          o_tc
);
    localparam logic [AW-1:0] FIRST = DOWN ? AW'(COUNT - 1) : '0;
    localparam logic [AW-1:0] LAST  = DOWN ? '0 : AW'(COUNT - 1);
    logic [AW-1:0] r_cnt;
    // step once per enabled cycle and snap back to the first index after the last one
    always_ff @(posedge clk) begin
        if (!rstn)
            r_cnt <= FIRST;
        else if (i_en)
            r_cnt <= o_tc ? FIRST : (DOWN ? r_cnt - AW'(1) : r_cnt + AW'(1));
    end
    assign o_cnt = r_cnt;
    assign o_tc  = r_cnt == LAST;
endmodule

// File: rtl/half_layer_sequencer.sv
// half_layer_sequencer: drives the shared dot-product datapath through one dense layer; optional ReLU via HALF_LAYER_SEQ_RELU_EN
module half_layer_sequencer
    import half_nn_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int LENGTH  = 10,
    parameter int MULTS   = 2,
    parameter int NEURONS = 4,
    localparam int CHUNKS = chunks_of(LENGTH, MULTS),
    localparam int WAW    = addr_w(NEURONS * CHUNKS),
    localparam int XAW    = addr_w(CHUNKS),
    localparam int NW     = addr_w(NEURONS),
    localparam int DW     = BITS * MULTS
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           w_rd,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  w_data,
    output logic           x_rd,
    output logic [XAW-1:0] x_addr,
    input  logic [DW-1:0]  x_data,
    output logic           dp_load_a,
    output logic [DW-1:0]  dp_vector_a_in,
    output logic           dp_in_valid,
    output logic [DW-1:0]  dp_vector_b,
    input  logic           dp_out_valid,
    input  logic [BITS-1:0] dp_c,
    output logic           y_valid,
    output logic [NW-1:0]  y_index,
    output logic [BITS-1:0] y_data,
    output logic           err
);
    seq_state_t     r_state, w_next;
    logic [NW-1:0]  r_neuron;
    logic           r_load_a, r_in_valid, r_y_valid, r_done, r_err;
    logic [NW-1:0]  r_y_index;
    logic [BITS-1:0] r_y_data, w_y_next;
    logic [XAW-1:0] w_ld_cnt, w_st_cnt;
    logic           w_ld_tc, w_st_tc, w_last, w_take;

    half_seq_addr_gen #(.COUNT(CHUNKS), .DOWN(1'b1), .AW(XAW)) u_ld_gen (
        .clk(clk), .rstn(rstn), .i_en(r_state == LOAD), .o_cnt(w_ld_cnt), .o_tc(w_ld_tc)
    );
    half_seq_addr_gen #(.COUNT(CHUNKS), .DOWN(1'b0), .AW(XAW)) u_st_gen (
        .clk(clk), .rstn(rstn), .i_en(r_state == STREAM), .o_cnt(w_st_cnt), .o_tc(w_st_tc)
    );

    assign w_last = r_neuron == NW'(NEURONS - 1);
    assign w_take = (r_state == WAIT) && dp_out_valid;

    // next-state: load weights, stream inputs, wait for the result, repeat per neuron
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = w_ld_tc ? STREAM : LOAD;
            STREAM:  w_next = w_st_tc ? WAIT : STREAM;
            WAIT:    w_next = dp_out_valid ? (w_last ? DONE : LOAD) : WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // neuron index: cleared on an accepted start, advanced when a non-final result arrives
    always_ff @(posedge clk) begin
        if (!rstn)
            r_neuron <= '0;
        else if (r_state == IDLE && start)
            r_neuron <= '0;
        else if (w_take && !w_last)
            r_neuron <= r_neuron + NW'(1);
    end

`ifdef HALF_LAYER_SEQ_RELU_EN
    assign w_y_next = dp_c[BITS-1] ? BITS'(HALF_ZERO) : dp_c;
`else
    assign w_y_next = dp_c;
`endif

    // read-latency alignment, result capture, done pulse and sticky protocol error
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_load_a   <= 1'b0;
            r_in_valid <= 1'b0;
            r_y_valid  <= 1'b0;
            r_y_index  <= '0;
            r_y_data   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_load_a   <= w_rd;
            r_in_valid <= x_rd;
            r_y_valid  <= w_take;
            if (w_take) begin
                r_y_index <= r_neuron;
                r_y_data  <= w_y_next;
            end
            r_done <= r_state == DONE;
            r_err  <= r_err | (dp_out_valid && r_state != WAIT);
        end
    end

    assign busy           = r_state != IDLE;
    assign done           = r_done;
    assign w_rd           = r_state == LOAD;
    assign w_addr         = w_rd ? WAW'(r_neuron) * WAW'(CHUNKS) + WAW'(w_ld_cnt) : '0;
    assign x_rd           = r_state == STREAM;
    assign x_addr         = x_rd ? w_st_cnt : '0;
    assign dp_load_a      = r_load_a;
    assign dp_vector_a_in = r_load_a ? w_data : '0;
    assign dp_in_valid    = r_in_valid;
    assign dp_vector_b    = r_in_valid ? x_data : '0;
    assign y_valid        = r_y_valid;
    assign y_index        = r_y_index;
    assign y_data         = r_y_data;
    assign err            = r_err;
endmodule
